// File: rtl/wb_master_pkg.sv
// rtl/wb_master_pkg.sv - shared types and constants for the Wishbone single-access master
package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_t;

    localparam logic [3:0] WB_SEL_FULL = 4'hF;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } wb_rsp_t;

    localparam wb_rsp_t RSP_CLEAR = '{rdata: 32'h0, err: 1'b0, timeout: 1'b0};

endpackage

// File: rtl/wb_intf.sv
// rtl/wb_intf.sv - Wishbone classic bus bundle with master and slave views
interface wb_bus_t;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_ms;
    logic        wb_ack;
    logic        wb_err;
    logic [31:0] wb_dat_sm;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_ms,
        input  wb_ack, wb_err, wb_dat_sm
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_ms,
        output wb_ack, wb_err, wb_dat_sm
    );
endinterface

// File: rtl/wb_master_ctrl.sv
// rtl/wb_master_ctrl.sv - valid/ready request to single Wishbone classic cycle, with misalign and timeout errors
//
// Ports:
//   clk, rst_i                      clock, synchronous active-high reset
//   req_valid_i/req_ready_o         request handshake; req_we_i, req_adr_i, req_be_i, req_wdata_i
//   rsp_valid_o/rsp_ready_i         response handshake; rsp_rdata_o, rsp_err_o, rsp_timeout_o
//   busy_o                          controller not idle
//   wb_bus                          Wishbone master view
module wb_master_ctrl
    import wb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_adr_i,
    input  logic [3:0]  req_be_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic        busy_o,
    wb_bus_t.master     wb_bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    wb_state_t        state_q, state_d;
    logic             we_q, we_d;
    logic [31:0]      adr_q, adr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    wb_rsp_t          rsp_q, rsp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            adr_q   <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rsp_q   <= RSP_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rsp_q   <= rsp_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rsp_d   = rsp_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    adr_d   = req_adr_i;
                    be_d    = req_be_i;
                    wdata_d = req_wdata_i;
                    if (req_adr_i[1:0] != 2'b00) begin
                        // Misaligned: answer with an error without touching the bus.
                        rsp_d   = '{rdata: 32'h0, err: 1'b1, timeout: 1'b0};
                        state_d = RESP;
                    end else begin
                        cnt_d   = '0;
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                // Slave answers take priority over the timeout in the limit cycle.
                if (wb_bus.wb_err) begin
                    rsp_d   = '{rdata: 32'h0, err: 1'b1, timeout: 1'b0};
                    state_d = RESP;
                end else if (wb_bus.wb_ack) begin
                    rsp_d   = '{rdata: (we_q ? 32'h0 : wb_bus.wb_dat_sm), err: 1'b0, timeout: 1'b0};
                    state_d = RESP;
                end else if (cnt_q == CNT_LIMIT) begin
                    rsp_d   = '{rdata: 32'h0, err: 1'b1, timeout: 1'b1};
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus outputs come straight from registers, so cyc/stb drop the same edge
    // the state leaves BUS (including reset) and never glitch with slave inputs.
    logic bus_active;
    assign bus_active = (state_q == BUS);

    assign wb_bus.wb_cyc    = bus_active;
    assign wb_bus.wb_stb    = bus_active;
    assign wb_bus.wb_we     = bus_active & we_q;
    assign wb_bus.wb_adr    = bus_active ? adr_q : 32'h0;
    assign wb_bus.wb_sel    = bus_active ? (we_q ? be_q : WB_SEL_FULL) : 4'h0;
    assign wb_bus.wb_dat_ms = bus_active ? wdata_q : 32'h0;

    assign req_ready_o   = (state_q == IDLE);
    assign rsp_valid_o   = (state_q == RESP);
    assign busy_o        = (state_q != IDLE);
    assign rsp_rdata_o   = rsp_q.rdata;
    assign rsp_err_o     = rsp_q.err;
    assign rsp_timeout_o = rsp_q.timeout;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// tb/tb_wb_master_ctrl.sv - directed self-checking bench for wb_master_ctrl
module tb_wb_master_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_adr_i;
    logic [3:0]  req_be_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        busy_o;

    wb_bus_t wb_if ();

    wb_master_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_adr_i    (req_adr_i),
        .req_be_i     (req_be_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .busy_o       (busy_o),
        .wb_bus       (wb_if.master)
    );

    always #5 clk = ~clk;

    // Timer slave: register at 0x8, 0x10 answers ack+err, silent mode never answers.
    logic        silent;
    logic [31:0] timer_q;
    logic        s_ack, s_err;
    logic [31:0] s_dat;

    always_comb begin
        s_ack = 1'b0;
        s_err = 1'b0;
        s_dat = 32'h0;
        if (wb_if.wb_cyc && wb_if.wb_stb && !silent) begin
            s_ack = 1'b1;
            if (wb_if.wb_adr == 32'h8) s_dat = timer_q;
            else if (wb_if.wb_adr == 32'h10) s_err = 1'b1;
        end
    end

    assign wb_if.wb_ack    = s_ack;
    assign wb_if.wb_err    = s_err;
    assign wb_if.wb_dat_sm = s_dat;

    always @(posedge clk) begin
        if (rst_i) begin
            timer_q <= 32'h0;
        end else if (s_ack && !s_err && wb_if.wb_we && wb_if.wb_adr == 32'h8) begin
            for (int b = 0; b < 4; b++)
                if (wb_if.wb_sel[b]) timer_q[8*b +: 8] <= wb_if.wb_dat_ms[8*b +: 8];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // lat counts cycles from request presentation: 1 = response in the cycle after accept.
    task automatic do_req(input logic we, input logic [31:0] adr, input logic [3:0] be,
                          input logic [31:0] wdata, input int hold,
                          output logic [31:0] rdata, output logic err, output logic tmo,
                          output int lat, output int ncyc, output logic [3:0] sel);
        logic done;
        done = 1'b0;
        lat = 0; ncyc = 0; sel = 4'h0; rdata = 32'h0; err = 1'b0; tmo = 1'b0;
        req_we_i = we; req_adr_i = adr; req_be_i = be; req_wdata_i = wdata;
        req_valid_i = 1'b1;
        rsp_ready_i = (hold == 0);
        check("req_ready_idle", req_ready_o, 1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            if (wb_if.wb_cyc) begin
                ncyc++;
                sel = wb_if.wb_sel;
            end
            if (rsp_valid_o) begin
                lat = k; rdata = rsp_rdata_o; err = rsp_err_o; tmo = rsp_timeout_o;
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) check("rsp_wait_bound", 0, 1);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", rsp_valid_o, 1);
            check("hold_req_ready", req_ready_o, 0);
            check("hold_rdata", rsp_rdata_o, rdata);
            @(posedge clk); #1;
        end
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        check("back_to_idle", busy_o, 0);
    endtask

    logic [31:0] rd;
    logic        er, tm;
    int          lat, ncyc;
    logic [3:0]  sel;

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_adr_i = 32'h0;
        req_be_i = 4'h0; req_wdata_i = 32'h0; rsp_ready_i = 1'b1; silent = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;

        check("rst_req_ready", req_ready_o, 1);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_err", {rsp_err_o, rsp_timeout_o}, 0);
        check("rst_rdata", rsp_rdata_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_cyc_stb_we", {wb_if.wb_cyc, wb_if.wb_stb, wb_if.wb_we}, 0);
        check("rst_adr", wb_if.wb_adr, 0);
        check("rst_sel", wb_if.wb_sel, 0);
        check("rst_dat_ms", wb_if.wb_dat_ms, 0);

        // Write 0x64 then read it back
        do_req(1'b1, 32'h8, 4'hF, 32'h0000_0064, 0, rd, er, tm, lat, ncyc, sel);
        check("wr_sel", sel, 4'hF);
        check("wr_lat", lat, 2);
        check("wr_ncyc", ncyc, 1);
        check("wr_err", er, 0);
        check("wr_rdata", rd, 0);
        do_req(1'b0, 32'h8, 4'h0, 32'h0, 0, rd, er, tm, lat, ncyc, sel);
        check("rd_sel", sel, 4'hF);
        check("rd_lat", lat, 2);
        check("rd_rdata", rd, 32'h0000_0064);
        check("rd_err", er, 0);

        // Byte write into 0xAABBCCDD
        do_req(1'b1, 32'h8, 4'hF, 32'hAABB_CCDD, 0, rd, er, tm, lat, ncyc, sel);
        do_req(1'b0, 32'h8, 4'h0, 32'h0, 0, rd, er, tm, lat, ncyc, sel);
        check("full_rdback", rd, 32'hAABB_CCDD);
        do_req(1'b1, 32'h8, 4'b0010, 32'h0000_1100, 0, rd, er, tm, lat, ncyc, sel);
        check("bw_sel", sel, 4'b0010);
        do_req(1'b0, 32'h8, 4'h0, 32'h0, 0, rd, er, tm, lat, ncyc, sel);
        check("bw_rdback", rd, 32'hAABB_11DD);

        // be=0 write still goes on the bus but changes nothing
        do_req(1'b1, 32'h8, 4'h0, 32'hFFFF_FFFF, 0, rd, er, tm, lat, ncyc, sel);
        check("be0_ncyc", ncyc, 1);
        check("be0_sel", sel, 4'h0);
        do_req(1'b0, 32'h8, 4'h0, 32'h0, 0, rd, er, tm, lat, ncyc, sel);
        check("be0_rdback", rd, 32'hAABB_11DD);

        // Bus error (ack+err)
        do_req(1'b0, 32'h10, 4'h0, 32'h0, 0, rd, er, tm, lat, ncyc, sel);
        check("berr_err", er, 1);
        check("berr_tmo", tm, 0);
        check("berr_rdata", rd, 0);

        // Misaligned
        do_req(1'b0, 32'h5, 4'h0, 32'h0, 0, rd, er, tm, lat, ncyc, sel);
        check("mis_ncyc", ncyc, 0);
        check("mis_lat", lat, 1);
        check("mis_err", er, 1);
        check("mis_tmo", tm, 0);

        // Timeout against a silent slave
        silent = 1'b1;
        do_req(1'b0, 32'h8, 4'h0, 32'h0, 0, rd, er, tm, lat, ncyc, sel);
        check("to_ncyc", ncyc, 8);
        check("to_lat", lat, 9);
        check("to_err", er, 1);
        check("to_tmo", tm, 1);
        check("to_rdata", rd, 0);
        silent = 1'b0;

        // Backpressure for 5 cycles
        do_req(1'b0, 32'h8, 4'h0, 32'h0, 5, rd, er, tm, lat, ncyc, sel);
        check("bp_rdata", rd, 32'hAABB_11DD);
        check("bp_err", er, 0);

        // Reset while in BUS
        silent = 1'b1;
        req_we_i = 1'b0; req_adr_i = 32'h8; req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        check("mid_cyc_before", wb_if.wb_cyc, 1);
        rst_i = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_cyc", wb_if.wb_cyc, 0);
        check("mid_rst_valid", rsp_valid_o, 0);
        check("mid_rst_ready", req_ready_o, 1);
        rst_i = 1'b0;
        silent = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_master_ctrl.md
Name: wb_master_ctrl

Overview:
Wishbone classic single-access master. It converts a simple valid/ready request/response interface into one `wb_bus_t` master cycle per request.
- Sits between a core or debug agent and the peripheral Wishbone bus (timer, other slaves).
- Handles slaves that ack combinationally in the same cycle.
- Converts bus errors and unresponsive slaves into an error response.

Parameters:
TIMEOUT_CYCLES, 256, cycles spent in BUS without wb_ack before abort with timeout error; legal range 1..65535.

Ports:
clk  input  1  clock
rst_i  input  1  synchronous active-high reset
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when valid&ready
req_we_i  input  1  1=write, 0=read
req_adr_i  input  32  byte address
req_be_i  input  4  write byte enables (ignored for reads)
req_wdata_i  input  32  write data
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumed when valid&ready
rsp_rdata_o  output  32  read data (0 for writes and errors)
rsp_err_o  output  1  access failed (bus error, misalignment or timeout)
rsp_timeout_o  output  1  failure was a timeout
busy_o  output  1  state != IDLE
wb_bus  interface  -  wb_bus_t.master: drives wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_ms; samples wb_ack, wb_err, wb_dat_sm

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_i, synchronous and active-high. All state updates on posedge clk.
- Reset values: state=IDLE, all captured fields=0, timeout counter=0. Resulting outputs: req_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_timeout_o=0, rsp_rdata_o=0, busy_o=0, wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_sel=0, wb_dat_ms=0.
- States: IDLE, BUS, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, capture we/adr/be/wdata.
  - If req_adr_i[1:0]!=0: go to RESP with err=1, timeout=0, rdata=0. No bus cycle is issued.
  - Otherwise go to BUS with counter cleared.
- BUS:
  - Drive from registered state/fields: wb_cyc=wb_stb=1, wb_we=captured we, wb_adr=captured adr, wb_dat_ms=captured wdata.
  - wb_sel = captured be for writes, 4'hF for reads.
  - Writes with be=0 are still issued on the bus.
  - wb_err=1 (with or without wb_ack): latch err=1, rdata=0, go to RESP.
  - wb_ack=1 and wb_err=0: latch err=0; rdata = wb_dat_sm for reads, 0 for writes; go to RESP.
  - Neither: increment counter. If counter==TIMEOUT_CYCLES-1, latch err=1, timeout=1, rdata=0, go to RESP.
  - Ack/err arriving in the same cycle as the timeout limit wins over timeout.
- RESP:
  - wb_cyc=wb_stb=0; rsp_valid_o=1 with stable rdata/err/timeout.
  - On rsp_ready_i go to IDLE. No new request is accepted in this cycle (req_ready_o=0).
- Latency with a combinational-ack slave:
  - Request accepted at edge N.
  - cyc/stb high during cycle N..N+1.
  - rsp_valid_o high after edge N+1.
  - Minimum 3 cycles per transaction, including return to IDLE.
- Exactly one cyc/stb cycle per ack. cyc/stb always drop for at least one cycle between transactions.
- Reset mid-transaction: at the rst_i edge, cyc/stb drop immediately and any pending response is discarded.
- Counter width: clog2(TIMEOUT_CYCLES+1). It never wraps because the abort happens first.

Decomposition:
- Package wb_master_pkg:
  - state enum {IDLE, BUS, RESP}.
  - WB_SEL_FULL=4'hF.
  - Response struct {rdata, err, timeout}.
- No sub-module: the timeout counter is an inline register.
- `wb_intf.sv` is included for `wb_bus_t`.

Test Plan:
- Write then read against the timer slave: write adr=0x8, be=4'hF, wdata=0x0000_0064, then read 0x8 -> wb_sel=4'hF on both, rsp_rdata_o=0x64, rsp_err_o=0, rsp_valid_o exactly 2 cycles after each accept.
- Byte write: read-back value 0xAABBCCDD, then write adr=0x8, be=4'b0010, wdata=0x0000_1100, then read -> wb_sel=4'b0010 during the write; read returns 0xAABB11DD.
- Bus error: read adr=0x10 to the timer -> slave returns wb_ack=1 and wb_err=1; expect rsp_err_o=1, rsp_timeout_o=0, rsp_rdata_o=0.
- Misaligned: read adr=0x5 -> wb_cyc never asserted; rsp_valid_o one cycle after accept with rsp_err_o=1.
- Timeout: silent slave model, TIMEOUT_CYCLES=8 -> wb_cyc high exactly 8 cycles, then rsp_err_o=1, rsp_timeout_o=1.
- Backpressure/reset: hold rsp_ready_i=0 for 5 cycles -> response stable and req_ready_o=0 throughout. Separately, assert rst_i while in BUS -> wb_cyc=0 and rsp_valid_o=0 the next cycle, req_ready_o=1.
